// File: rtl/sa_pkg.sv
// Shared types and defaults for the systolic-array processing elements.
package sa_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 20;
  localparam int DEF_ROWS   = 16;

  // The accumulator must hold at least one full-width product.
  function automatic bit acc_w_ok(input int data_w, input int acc_w);
    return acc_w >= 2 * data_w;
  endfunction

endpackage

// File: rtl/sa_mac_sat.sv
// Combinational multiply-accumulate step with signed/unsigned operands and
// optional saturation of the accumulator range.
module sa_mac_sat
  import sa_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [ACC_W-1:0]  i_acc,
  input  logic              i_mode_signed,
  input  logic              i_sat_en,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_ovf
);

  localparam int PW  = 2 * DATA_W;
  localparam int EXT = ACC_W + 1 - PW;

  logic [PW-1:0]  w_a_ext;
  logic [PW-1:0]  w_b_ext;
  logic [PW-1:0]  w_prod;
  logic [ACC_W:0] w_prod_ext;
  logic [ACC_W:0] w_acc_ext;
  logic [ACC_W:0] w_sum;

  // Low PW bits of the product of extended operands equal the true product in either mode.
  assign w_a_ext    = {{DATA_W{i_mode_signed & i_a[DATA_W-1]}}, i_a};
  assign w_b_ext    = {{DATA_W{i_mode_signed & i_b[DATA_W-1]}}, i_b};
  assign w_prod     = w_a_ext * w_b_ext;
  assign w_prod_ext = {{EXT{i_mode_signed & w_prod[PW-1]}}, w_prod};
  assign w_acc_ext  = {i_mode_signed & i_acc[ACC_W-1], i_acc};
  assign w_sum      = w_acc_ext + w_prod_ext;

  // Range check on the widened sum, then clamp or wrap.
  always_comb begin
    o_sum = w_sum[ACC_W-1:0];
    if (i_mode_signed) begin
      o_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];
    end else begin
      o_ovf = w_sum[ACC_W];
    end
    if (o_ovf && i_sat_en) begin
      if (!i_mode_signed) begin
        o_sum = {ACC_W{1'b1}};
      end else if (w_sum[ACC_W]) begin
        o_sum = {1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        o_sum = {1'b0, {(ACC_W-1){1'b1}}};
      end
    end else begin
      o_sum = w_sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/sa_pe_last_row_p.sv
// Bottom-row output-stationary PE: accumulates operand pairs, forwards the row
// operand, and drains its own sum plus ROWS-1 sums from above over valid/ready.
module sa_pe_last_row_p
  import sa_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int ROWS   = DEF_ROWS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sync_clr,
  input  logic              mode_signed,
  input  logic              sat_en,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              in_valid,
  input  logic              in_last,
  output logic [DATA_W-1:0] a_out,
  output logic              a_out_valid,
  input  logic [ACC_W-1:0]  psum_in,
  input  logic              psum_in_valid,
  output logic              psum_in_ready,
  output logic [ACC_W-1:0]  psum_out,
  output logic              psum_out_valid,
  input  logic              psum_out_ready,
  output logic              busy,
  output logic              ovf
);

  localparam int CNT_W = $clog2(ROWS + 1);
  localparam logic [CNT_W-1:0] ROWS_C = CNT_W'(ROWS);

  if (!acc_w_ok(DATA_W, ACC_W)) begin : g_acc_w_chk
    $error("ACC_W must be at least 2*DATA_W");
  end
  if (ROWS < 1) begin : g_rows_chk
    $error("ROWS must be at least 1");
  end

  state_e            r_state,          w_state_nxt;
  logic [ACC_W-1:0]  r_acc,            w_acc_nxt;
  logic [CNT_W-1:0]  r_loaded,         w_loaded_nxt;
  logic              r_ovf,            w_ovf_nxt;
  logic [ACC_W-1:0]  r_psum_out,       w_psum_out_nxt;
  logic              r_psum_out_valid, w_psum_out_valid_nxt;
  logic [DATA_W-1:0] r_a_out,          w_a_out_nxt;
  logic              r_a_out_valid,    w_a_out_valid_nxt;
  logic              r_busy,           w_busy_nxt;

  logic [ACC_W-1:0]  w_mac_sum;
  logic              w_mac_ovf;
  logic              w_in_ready;
  logic              w_in_xfer;
  logic              w_out_xfer;

  sa_mac_sat #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .i_a           (a_in),
    .i_b           (b_in),
    .i_acc         (r_acc),
    .i_mode_signed (mode_signed),
    .i_sat_en      (sat_en),
    .o_sum         (w_mac_sum),
    .o_ovf         (w_mac_ovf)
  );

  assign w_in_ready = (r_state == DRAIN) && (r_loaded < ROWS_C) &&
                      (!r_psum_out_valid || psum_out_ready);
  assign w_in_xfer  = psum_in_valid && w_in_ready;
  assign w_out_xfer = r_psum_out_valid && psum_out_ready;

  // Next-state and datapath decisions for accumulate, load and drain.
  always_comb begin
    w_state_nxt          = r_state;
    w_acc_nxt            = r_acc;
    w_loaded_nxt         = r_loaded;
    w_ovf_nxt            = r_ovf;
    w_psum_out_nxt       = r_psum_out;
    w_psum_out_valid_nxt = r_psum_out_valid;
    w_a_out_nxt          = r_a_out;
    w_a_out_valid_nxt    = 1'b0;
    if (sync_clr) begin
      w_state_nxt          = IDLE;
      w_acc_nxt            = {ACC_W{1'b0}};
      w_loaded_nxt         = {CNT_W{1'b0}};
      w_ovf_nxt            = 1'b0;
      w_psum_out_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE, MAC: begin
          w_a_out_nxt       = a_in;
          w_a_out_valid_nxt = in_valid;
          if (in_valid) begin
            w_acc_nxt = w_mac_sum;
            w_ovf_nxt = r_ovf | w_mac_ovf;
            if (in_last) begin
              w_psum_out_nxt       = w_mac_sum;
              w_psum_out_valid_nxt = 1'b1;
              w_loaded_nxt         = CNT_W'(1);
              w_state_nxt          = DRAIN;
            end else begin
              w_state_nxt = MAC;
            end
          end else begin
            w_state_nxt = r_state;
          end
        end
        DRAIN: begin
          if (w_in_xfer) begin
            w_psum_out_nxt       = psum_in;
            w_psum_out_valid_nxt = 1'b1;
            w_loaded_nxt         = r_loaded + CNT_W'(1);
          end else if (w_out_xfer) begin
            w_psum_out_valid_nxt = 1'b0;
            // The last of the ROWS words just left: the tile is complete.
            if (r_loaded == ROWS_C) begin
              w_state_nxt  = IDLE;
              w_acc_nxt    = {ACC_W{1'b0}};
              w_loaded_nxt = {CNT_W{1'b0}};
              w_ovf_nxt    = 1'b0;
            end else begin
              w_state_nxt = DRAIN;
            end
          end else begin
            w_state_nxt = DRAIN;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
    w_busy_nxt = (w_state_nxt == DRAIN);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state          <= IDLE;
      r_acc            <= {ACC_W{1'b0}};
      r_loaded         <= {CNT_W{1'b0}};
      r_ovf            <= 1'b0;
      r_psum_out       <= {ACC_W{1'b0}};
      r_psum_out_valid <= 1'b0;
      r_a_out          <= {DATA_W{1'b0}};
      r_a_out_valid    <= 1'b0;
      r_busy           <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_acc            <= w_acc_nxt;
      r_loaded         <= w_loaded_nxt;
      r_ovf            <= w_ovf_nxt;
      r_psum_out       <= w_psum_out_nxt;
      r_psum_out_valid <= w_psum_out_valid_nxt;
      r_a_out          <= w_a_out_nxt;
      r_a_out_valid    <= w_a_out_valid_nxt;
      r_busy           <= w_busy_nxt;
    end
  end

  assign a_out          = r_a_out;
  assign a_out_valid    = r_a_out_valid;
  assign psum_in_ready  = w_in_ready;
  assign psum_out       = r_psum_out;
  assign psum_out_valid = r_psum_out_valid;
  assign busy           = r_busy;
  assign ovf            = r_ovf;

endmodule

// File: tb/tb_sa_pe_last_row_p.sv
// Self-checking bench for sa_pe_last_row_p: directed tiles with literal
// expectations plus randomized tiles scored against a behavioural model.
module tb_sa_pe_last_row_p;

  localparam int DW   = 8;
  localparam int AW   = 20;
  localparam int ROWS = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sync_clr = 1'b0;
  logic          mode_signed = 1'b0;
  logic          sat_en = 1'b0;
  logic [DW-1:0] a_in = '0;
  logic [DW-1:0] b_in = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [DW-1:0] a_out;
  logic          a_out_valid;
  logic [AW-1:0] psum_in = '0;
  logic          psum_in_valid = 1'b0;
  logic          psum_in_ready;
  logic [AW-1:0] psum_out;
  logic          psum_out_valid;
  logic          psum_out_ready = 1'b1;
  logic          busy;
  logic          ovf;

  sa_pe_last_row_p #(.DATA_W(DW), .ACC_W(AW), .ROWS(ROWS)) dut (
    .clk            (clk),
    .rst            (rst),
    .sync_clr       (sync_clr),
    .mode_signed    (mode_signed),
    .sat_en         (sat_en),
    .a_in           (a_in),
    .b_in           (b_in),
    .in_valid       (in_valid),
    .in_last        (in_last),
    .a_out          (a_out),
    .a_out_valid    (a_out_valid),
    .psum_in        (psum_in),
    .psum_in_valid  (psum_in_valid),
    .psum_in_ready  (psum_in_ready),
    .psum_out       (psum_out),
    .psum_out_valid (psum_out_valid),
    .psum_out_ready (psum_out_ready),
    .busy           (busy),
    .ovf            (ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int feed_base = 0;
  bit feed_gap = 1'b0;

  // Behavioural model state.
  longint        m_acc = 0;
  bit            m_ovf = 1'b0;
  bit            m_drain = 1'b0;
  int            m_left = 0;
  int            m_acc_in = 0;
  bit            exp_aov = 1'b0;
  logic [DW-1:0] exp_aout = '0;
  bit            exp_ready;
  bit            ov_step;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] got_q[$];
  bit            got_ovf_q[$];
  int            xfer_cyc[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Plain-integer accumulate step: exact sum, then clamp or wrap into range.
  function automatic longint mstep(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   input bit sg, input bit sat, input longint acc,
                                   output bit ov);
    longint ai, bi, s, lo, hi, span;
    ai   = sg ? longint'($signed(a)) : longint'(a);
    bi   = sg ? longint'($signed(b)) : longint'(b);
    span = longint'(1) <<< AW;
    lo   = sg ? -(longint'(1) <<< (AW - 1)) : 64'sd0;
    hi   = sg ? (longint'(1) <<< (AW - 1)) - 1 : span - 1;
    s    = acc + ai * bi;
    ov   = 1'b0;
    if (s < lo || s > hi) begin
      ov = 1'b1;
      if (sat) s = (s < lo) ? lo : hi;
      else     s = (((s - lo) % span) + span) % span + lo;
    end
    return s;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Upstream PE model: offers feed_base + (words accepted so far this tile).
  always @(posedge clk) begin
    #2;
    psum_in       = AW'(feed_base + m_acc_in);
    psum_in_valid = feed_gap ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Compare DUT against the model, then advance the model by this cycle's inputs.
  always @(negedge clk) begin
    if (!rst) begin
      m_acc = 0; m_ovf = 1'b0; m_drain = 1'b0; m_left = 0; m_acc_in = 0;
      exp_aov = 1'b0;
      exp_q.delete();
    end else begin
      exp_ready = m_drain && (m_acc_in < ROWS - 1) && (exp_q.size() == 0 || psum_out_ready);
      chk("busy", busy, m_drain);
      chk("ovf", ovf, m_ovf);
      chk("psum_out_valid", psum_out_valid, (exp_q.size() > 0) ? 1 : 0);
      if (exp_q.size() > 0) chk("psum_out", psum_out, exp_q[0]);
      chk("psum_in_ready", psum_in_ready, exp_ready);
      chk("a_out_valid", a_out_valid, exp_aov);
      if (exp_aov) chk("a_out", a_out, exp_aout);
      if (sync_clr) begin
        m_acc = 0; m_ovf = 1'b0; m_drain = 1'b0; m_left = 0; m_acc_in = 0;
        exp_aov = 1'b0;
        exp_q.delete();
      end else begin
        exp_aov = in_valid && !m_drain;
        if (!m_drain) exp_aout = a_in;
        if (m_drain) begin
          if (exp_q.size() > 0 && psum_out_ready) begin
            got_q.push_back(psum_out);
            got_ovf_q.push_back(ovf);
            xfer_cyc.push_back(cyc);
            void'(exp_q.pop_front());
            m_left--;
          end
          if (psum_in_valid && exp_ready) begin
            exp_q.push_back(psum_in);
            m_acc_in++;
          end
          if (m_left == 0) begin
            m_drain = 1'b0; m_acc = 0; m_ovf = 1'b0;
          end
        end else if (in_valid) begin
          m_acc = mstep(a_in, b_in, mode_signed, sat_en, m_acc, ov_step);
          m_ovf = m_ovf | ov_step;
          if (in_last) begin
            exp_q.push_back(AW'(m_acc));
            m_drain = 1'b1; m_left = ROWS; m_acc_in = 0;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // rmode: 0 ready held high, 1 stall 5 cycles then toggle, 2 random.
  task automatic drain(input int rmode);
    int c;
    c = 0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    while ((busy || psum_out_valid) && c < 200) begin
      if (rmode == 0)      psum_out_ready = 1'b1;
      else if (rmode == 1) psum_out_ready = (c < 5) ? 1'b0 : ((c % 2) == 1);
      else                 psum_out_ready = 1'($urandom_range(0, 1));
      step();
      c++;
    end
    psum_out_ready = 1'b1;
    chk("drain_done", longint'(busy | psum_out_valid), 0);
  endtask

  task automatic run_tile(input int n, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input bit sg, input bit sat, input bit rnd, input int rmode);
    mode_signed    = sg;
    sat_en         = sat;
    psum_out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (rnd && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        step();
      end
      in_valid = 1'b1;
      in_last  = (i == n - 1);
      a_in     = rnd ? DW'($urandom) : a;
      b_in     = rnd ? DW'($urandom) : b;
      step();
    end
    drain(rmode);
  endtask

  int g;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    chk("rst_a_out", a_out, 0);
    chk("rst_a_out_valid", a_out_valid, 0);
    chk("rst_psum_out", psum_out, 0);
    chk("rst_psum_out_valid", psum_out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b1;
    step();

    // Signed accumulate and full-rate drain of words 1..15.
    feed_base = 1; feed_gap = 1'b0;
    g = got_q.size();
    run_tile(16, 8'h80, 8'h80, 1'b1, 1'b1, 1'b0, 0);
    chk("t1_count", got_q.size() - g, 16);
    chk("t1_own", got_q[g], 20'd262144);
    chk("t1_ovf", got_ovf_q[g], 0);
    for (int k = 1; k < ROWS; k++) chk("t1_word", got_q[g + k], k);
    chk("t1_rate", xfer_cyc[g + 15] - xfer_cyc[g], 15);
    chk("t1_busy", busy, 0);

    g = got_q.size();
    run_tile(32, 8'h80, 8'h80, 1'b1, 1'b1, 1'b0, 0);
    chk("t2_sat_own", got_q[g], 20'd524287);
    chk("t2_sat_ovf", got_ovf_q[g], 1);
    g = got_q.size();
    run_tile(32, 8'h80, 8'h80, 1'b1, 1'b0, 1'b0, 0);
    chk("t2_wrap_own", got_q[g], 20'h80000);
    chk("t2_wrap_ovf", got_ovf_q[g], 1);

    g = got_q.size();
    run_tile(17, 8'hff, 8'hff, 1'b0, 1'b1, 1'b0, 0);
    chk("t3_sat_own", got_q[g], 20'd1048575);
    chk("t3_sat_ovf", got_ovf_q[g], 1);
    g = got_q.size();
    run_tile(16, 8'hff, 8'hff, 1'b0, 1'b1, 1'b0, 0);
    chk("t3_fit_own", got_q[g], 20'd1040400);
    chk("t3_fit_ovf", got_ovf_q[g], 0);

    // Backpressure: no loss or duplication across stalls.
    feed_base = 100;
    g = got_q.size();
    run_tile(5, 8'd3, 8'd7, 1'b0, 1'b0, 1'b0, 1);
    chk("t4_count", got_q.size() - g, 16);
    chk("t4_own", got_q[g], 20'd105);
    for (int k = 1; k < ROWS; k++) chk("t4_word", got_q[g + k], 99 + k);

    // Synchronous clear mid-drain, then a one-beat tile.
    feed_base = 1;
    mode_signed = 1'b1; sat_en = 1'b1;
    g = got_q.size();
    for (int i = 0; i < 32; i++) begin
      in_valid = 1'b1; in_last = (i == 31); a_in = 8'h80; b_in = 8'h80;
      step();
    end
    in_valid = 1'b0; in_last = 1'b0; psum_out_ready = 1'b1;
    for (int c = 0; c < 50 && (got_q.size() - g) < 4; c++) step();
    chk("t5_words_before_clr", got_q.size() - g, 4);
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    chk("t5_clr_busy", busy, 0);
    chk("t5_clr_valid", psum_out_valid, 0);
    chk("t5_clr_ovf", ovf, 0);
    g = got_q.size();
    run_tile(1, 8'd3, 8'd5, 1'b0, 1'b0, 1'b0, 0);
    chk("t5_own", got_q[g], 20'd15);

    // Row forwarding, and suppression of a_out_valid during drain.
    mode_signed = 1'b0; sat_en = 1'b0;
    in_valid = 1'b1; in_last = 1'b0; b_in = 8'd0;
    for (int k = 1; k <= 3; k++) begin
      a_in = DW'(k);
      step();
      chk("t6_a_out", a_out, k);
      chk("t6_a_out_valid", a_out_valid, 1);
    end
    in_last = 1'b1; a_in = 8'd4;
    step();
    in_last = 1'b0; psum_out_ready = 1'b0;
    repeat (3) begin
      step();
      chk("t6_drain_a_out_valid", a_out_valid, 0);
    end
    drain(0);

    // Asynchronous reset in the middle of an overflowing MAC phase.
    mode_signed = 1'b0; sat_en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; in_last = 1'b0; a_in = 8'hff; b_in = 8'hff;
      step();
    end
    #3;
    rst = 1'b0;
    #1;
    chk("t7_a_out", a_out, 0);
    chk("t7_a_out_valid", a_out_valid, 0);
    chk("t7_psum_out", psum_out, 0);
    chk("t7_psum_out_valid", psum_out_valid, 0);
    chk("t7_busy", busy, 0);
    chk("t7_ovf", ovf, 0);
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();

    // Randomized tiles with random gaps, operands, modes and backpressure.
    feed_gap = 1'b1;
    repeat (25) begin
      feed_base = $urandom_range(0, 100000);
      g = got_q.size();
      run_tile($urandom_range(1, 40), 8'd0, 8'd0, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'b1, 2);
      chk("rand_count", got_q.size() - g, ROWS);
    end

    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sa_pe_last_row_p.md
# sa_pe_last_row_p

Parametrised output-stationary processing element for the bottom row of the systolic array. Accumulates a stream of operand pairs, forwards the row operand to its right-hand neighbour, and on end-of-tile drains its own sum followed by `ROWS-1` partial sums from the column above. Draining uses a valid/ready handshake toward the accumulator/activation stage. It adds signed/unsigned mode, saturation with a sticky overflow flag, and backpressure-safe draining.

## Interface
- `DATA_W`, 8: operand width.
- `ACC_W`, 20: accumulator and partial-sum width. Must satisfy `ACC_W >= 2*DATA_W`.
- `ROWS`, 16: PEs per column. This is the number of words drained per tile. Must be ≥1.
- `clk` input 1: clock; all logic on the rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `sync_clr` input 1: synchronous clear; highest priority after `rst`.
- `mode_signed` input 1: 1 selects two's-complement operands; 0 selects unsigned.
- `sat_en` input 1: 1 saturates the accumulator; 0 wraps it.
- `a_in` input DATA_W: row operand from the left.
- `b_in` input DATA_W: column operand from above.
- `in_valid` input 1: `a_in`/`b_in` beat is valid.
- `in_last` input 1: qualifies the final beat of the tile; only meaningful when `in_valid=1`.
- `a_out` output DATA_W: registered `a_in` for the right neighbour.
- `a_out_valid` output 1: registered `in_valid` for the right neighbour.
- `psum_in` input ACC_W: partial sum drained from the PE above.
- `psum_in_valid` input 1: `psum_in` is valid.
- `psum_in_ready` output 1: this PE accepts `psum_in` this cycle.
- `psum_out` output ACC_W: drained word.
- `psum_out_valid` output 1: `psum_out` is valid.
- `psum_out_ready` input 1: the downstream stage accepts `psum_out`.
- `busy` output 1: high in DRAIN. While it is high, upstream must hold `in_valid=0`.
- `ovf` output 1: sticky flag; set on any accumulator overflow in the current tile.

## Operation
- **States.**
  - IDLE: accumulator = 0.
  - MAC: accumulating.
  - DRAIN: outputting words.
- **IDLE → MAC** on any beat with `in_valid=1`. That beat is accumulated.
  - If that beat also has `in_last=1`, go directly IDLE → DRAIN.
- **Product.** `a_in*b_in` is computed at 2*DATA_W bits, signed or unsigned per `mode_signed`. It is then sign- or zero-extended to ACC_W+1 bits and added to the accumulator.
- **Range check.** If the ACC_W+1-bit sum is outside the ACC_W range (signed or unsigned), set `ovf`. Then:
  - `sat_en=1`: clamp to the range limit.
  - `sat_en=0`: truncate (wrap).
- `mode_signed` and `sat_en` must be stable for the whole tile. Changing them mid-tile gives undefined results.
- **Beat with `in_valid=1` and `in_last=1` in MAC or IDLE.** The final sum is loaded directly into `psum_out`, `psum_out_valid` is set, `loaded` is set to 1, and the state becomes DRAIN.
- **DRAIN handshake.**
  - `psum_in_ready = (state==DRAIN) && (loaded<ROWS) && (!psum_out_valid || psum_out_ready)`.
  - On `psum_in_valid && psum_in_ready`: load `psum_out` from `psum_in` and increment `loaded`.
  - `psum_out_valid` clears on an output transfer that has no simultaneous load.
- **End of drain.** When the `ROWS`-th word transfers out: go to IDLE, clear the accumulator, `loaded` and `ovf`.
- **In DRAIN:** `in_valid` is ignored and `a_out_valid=0`.
- **`sync_clr`:** go to IDLE; clear the accumulator, `loaded`, `ovf`, `psum_out_valid` and `a_out_valid`. This applies in any state, including mid-drain.

## Timing
- **Reset values.** `rst` low clears, asynchronously:
  - `a_out=0`, `a_out_valid=0`;
  - `psum_out=0`, `psum_out_valid=0`;
  - `busy=0`, `ovf=0`;
  - state IDLE, accumulator 0.
- **Row forwarding.** `a_out`/`a_out_valid` have 1-cycle latency in IDLE and MAC.
- **Accumulator.** The update is visible one cycle after the beat.
- **Own word.** `psum_out_valid` rises on the clock edge that samples the last beat.
- **Drain throughput.** With `psum_out_ready=1` and `psum_in_valid=1` held, drain runs at 1 word/cycle. Word k is valid in cycle T+1+k; the full drain occupies `ROWS` cycles.
- `psum_out` is held stable while `psum_out_valid && !psum_out_ready`.
- **`ROWS=1`.** Only the own word is emitted. `psum_in_ready` never asserts.
- **Counter width.** `loaded` is `$clog2(ROWS+1)` bits and never wraps.

## Structure
- **Package `sa_pkg`:**
  - state enum (IDLE/MAC/DRAIN);
  - default `DATA_W`/`ACC_W`/`ROWS` localparams;
  - the `ACC_W >= 2*DATA_W` check, as an elaboration assertion.
- **Sub-module `sa_mac_sat`:** combinational multiply, extend, add, and saturate-or-wrap.
  - Inputs: operands, accumulator, `mode_signed`, `sat_en`.
  - Outputs: new sum, overflow.
- **Top level:** FSM, forwarding registers and drain handshake.

## Test plan
- **Signed accumulate and drain.** Signed mode; 16 beats of `a=-128, b=-128`, last beat with `in_last`. Required: own word `262144`, `ovf=0`. With `psum_in` = 1..15 and `psum_out_ready` held high, `psum_out` = 262144, 1, …, 15 on consecutive cycles; then IDLE, `busy=0`.
- **Signed saturation.** Signed mode, `sat_en=1`, 32 beats of `-128×-128`. Required: `psum_out=524287`, `ovf=1`. Repeat with `sat_en=0`: `psum_out=-524288`.
- **Unsigned saturation.** Unsigned mode, `sat_en=1`, 17 beats of `255×255`. Required: `psum_out=1048575`, `ovf=1`. With 16 beats instead: `1040400`, `ovf=0`.
- **Backpressure.** During drain, hold `psum_out_ready=0` for 5 cycles, then toggle it every other cycle. Required:
  - `psum_out` stable while stalled;
  - `psum_in_ready=0` while stalled;
  - no word lost or duplicated;
  - exactly 16 transfers.
- **Clear and reset mid-drain.** Assert `sync_clr` after word 4 of the drain. Required next cycle: IDLE, `psum_out_valid=0`, `ovf=0`. A following 1-beat tile `3×5` with `in_last` yields `15`. Also assert `rst` mid-MAC: all outputs go to 0 immediately.
- **Row forwarding.** Drive `a_in` = 1, 2, 3 with `in_valid` → `a_out` = 1, 2, 3 one cycle later. During DRAIN, `a_out_valid` stays 0 despite `in_valid=1`.
